// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register controller.
// Command byte layout, FSM states and fixed byte values.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    RD_REQ,
    RD_WAIT,
    DRAIN
  } state_e;

  localparam int CMD_RW = 7;
  localparam int CMD_AI = 6;

  localparam logic [5:0] STATUS_ADDR = 6'h3F;
  localparam logic [7:0] DRAIN_BYTE  = 8'hFF;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Register bank bus between the SPI controller and the bank.
// Read data is valid exactly one cycle after reg_re.
interface spi_reg_ctrl_if #(
  parameter int ADDR_W = 6
);

  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );

endinterface

// File: rtl/spi_reg_ctrl.sv
// Byte-level command controller between SPI slave and register bank.
// Decodes the command byte, sequences writes/reads, tracks frames and errors.
module spi_reg_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int         ADDR_W    = 6,
  parameter int         NUM_REGS  = 64,
  parameter logic [7:0] STATUS_ID = 8'h41
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       msg_start,
  input  logic       msg_end,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic [7:0] tx_byte,
  output logic       tx_load,
  output logic [7:0] frame_cnt,
  output logic       err,
  spi_reg_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] NREG =
    (ADDR_W+1)'(NUM_REGS);
  localparam bit HAS_STAT = NUM_REGS <= 63;

  state_e            state_q, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              ai_q, ai_n;
  logic              stat_q, stat_n;
  logic [1:0]        ph_q, ph_n;
  logic [7:0]        tx_q, tx_n;
  logic              ld_q, ld_n;
  logic [ADDR_W-1:0] raddr_q, raddr_n;
  logic [7:0]        wd_q, wd_n;
  logic              we_q, we_n;
  logic              re_q, re_n;
  logic [7:0]        fc_q, fc_n;
  logic              err_q, err_n;

  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_bad;
  logic              cmd_stat;

  function automatic logic [ADDR_W-1:0] inc(
    input logic [ADDR_W-1:0] a
  );
    return (a == LAST) ? '0 : a + ADDR_W'(1);
  endfunction

  function automatic logic [7:0] stat_byte(
    input logic e
  );
    return {e, STATUS_ID[6:0]};
  endfunction

  assign cmd_addr = rx_byte[ADDR_W-1:0];
  assign cmd_bad  = {1'b0, cmd_addr} >= NREG;
  assign cmd_stat = HAS_STAT &&
                    rx_byte[CMD_RW] &&
                    rx_byte[5:0] == STATUS_ADDR;

  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    ai_n    = ai_q;
    stat_n  = stat_q;
    ph_n    = ph_q;
    tx_n    = tx_q;
    ld_n    = 1'b0;
    raddr_n = raddr_q;
    wd_n    = wd_q;
    we_n    = 1'b0;
    re_n    = 1'b0;
    fc_n    = fc_q;
    err_n   = err_q;

    // A byte arriving with msg_end is still written
    if (state_q == WR && rx_valid) begin
      we_n    = 1'b1;
      wd_n    = rx_byte;
      raddr_n = addr_q;
      if (ai_q) addr_n = inc(addr_q);
    end

    if (msg_end) begin
      state_n = IDLE;
      fc_n    = fc_q + 8'd1;
    end else if (msg_start) begin
      if (state_q != IDLE) err_n = 1'b1;
      state_n = CMD;
      tx_n    = stat_byte(err_n);
      ld_n    = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        CMD: begin
          if (rx_valid) begin
            ai_n   = rx_byte[CMD_AI];
            addr_n = cmd_addr;
            stat_n = cmd_stat;
            if (cmd_stat) begin
              state_n = RD_REQ;
            end else if (cmd_bad) begin
              err_n   = 1'b1;
              state_n = DRAIN;
              tx_n    = DRAIN_BYTE;
              ld_n    = 1'b1;
            end else if (rx_byte[CMD_RW]) begin
              state_n = RD_REQ;
            end else begin
              state_n = WR;
            end
          end
        end
        WR: ;
        RD_REQ: begin
          re_n    = !stat_q;
          raddr_n = addr_q;
          ph_n    = 2'd0;
          state_n = RD_WAIT;
        end
        RD_WAIT: begin
          // ph 0: bank latency, ph 1: load, ph 2: await dummy
          case (ph_q)
            2'd0: ph_n = 2'd1;
            2'd1: begin
              ld_n = 1'b1;
              ph_n = 2'd2;
              if (stat_q) begin
                tx_n  = stat_byte(err_q);
                err_n = 1'b0;
              end else begin
                tx_n = bus.reg_rdata;
              end
              if (ai_q) addr_n = inc(addr_q);
            end
            default: begin
              if (rx_valid) state_n = RD_REQ;
            end
          endcase
        end
        DRAIN: tx_n = DRAIN_BYTE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ai_q    <= 1'b0;
      stat_q  <= 1'b0;
      ph_q    <= 2'd0;
      tx_q    <= 8'h00;
      ld_q    <= 1'b0;
      raddr_q <= '0;
      wd_q    <= 8'h00;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      fc_q    <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      ai_q    <= ai_n;
      stat_q  <= stat_n;
      ph_q    <= ph_n;
      tx_q    <= tx_n;
      ld_q    <= ld_n;
      raddr_q <= raddr_n;
      wd_q    <= wd_n;
      we_q    <= we_n;
      re_q    <= re_n;
      fc_q    <= fc_n;
      err_q   <= err_n;
    end
  end

  assign tx_byte       = tx_q;
  assign tx_load       = ld_q;
  assign frame_cnt     = fc_q;
  assign err           = err_q;
  assign bus.reg_addr  = raddr_q;
  assign bus.reg_wdata = wd_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;

endmodule
